// File: rtl/value_delay_pkg.sv
`default_nettype none
// ==== value_delay_pkg | FSM state type and latency clamp shared by value_delay_line | rev 1.0 ====
package value_delay_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } vdl_state_t;

    // Requested latency folded into the legal range 1..depth.
    function automatic logic [31:0] clamp_delay(input logic [31:0] sel, input logic [31:0] depth);
        logic [31:0] r;
        if (sel == 32'd0) begin
            r = 32'd1;
        end else if (sel > depth) begin
            r = depth;
        end else begin
            r = sel;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_stage.sv
`default_nettype none
// ==== delay_stage | one valid+data pipeline register of value_delay_line | rev 1.0 ====
module delay_stage
    import value_delay_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/value_delay_line.sv
`default_nettype none
// ==== value_delay_line | programmable-latency valid/data delay line, latency 1..DEPTH | rev 1.0 ====
// Optional occupancy output enabled by defining VALUE_DELAY_LINE_OCC_EN.
module value_delay_line
    import value_delay_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [$clog2(DEPTH):0] delay_sel,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] cur_delay
`ifdef VALUE_DELAY_LINE_OCC_EN
    ,
    output logic [$clog2(DEPTH):0] occ
`endif
);

    localparam int c_SEL_W = $clog2(DEPTH) + 1;

    vdl_state_t          state_q, state_d;
    logic [c_SEL_W-1:0]  cur_delay_q, cur_delay_d;
    logic [WIDTH-1:0]    out_hold_q, out_hold_d;

    logic [DEPTH-1:0]    stage_valid_d, stage_valid_q;
    logic [WIDTH-1:0]    stage_data_d [DEPTH];
    logic [WIDTH-1:0]    stage_data_q [DEPTH];

    logic [DEPTH-1:0]    w_window;
    logic [DEPTH-1:0]    w_inner;
    logic                w_tap_valid;
    logic [WIDTH-1:0]    w_tap_data;

    // w_window: stages in front of or at the tap; w_inner: stages that stay inside after one shift.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_window[k] = (c_SEL_W'(k) < cur_delay_q);
            w_inner[k]  = (c_SEL_W'(k + 1) < cur_delay_q);
        end
    end

    // Samples are dropped once they pass the tap so a later, longer latency never sees stale ones.
    always_comb begin
        stage_valid_d[0] = in_valid & w_window[0] & ~flush;
        stage_data_d[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            stage_valid_d[k] = stage_valid_q[k-1] & w_window[k] & ~flush;
            stage_data_d[k]  = stage_data_q[k-1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        delay_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .valid_i (stage_valid_d[k]),
            .data_i  (stage_data_d[k]),
            .valid_o (stage_valid_q[k]),
            .data_o  (stage_data_q[k])
        );
    end

    always_comb begin
        w_tap_valid = 1'b0;
        w_tap_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (cur_delay_q == c_SEL_W'(k + 1)) begin
                w_tap_valid = stage_valid_q[k];
                w_tap_data  = stage_data_q[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_delay_d = cur_delay_q;
        out_hold_d  = w_tap_valid ? w_tap_data : out_hold_q;

        if ((state_q == IDLE) && !in_valid) begin
            cur_delay_d = c_SEL_W'(clamp_delay(32'(delay_sel), 32'(DEPTH)));
        end

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (!in_valid && !(|(stage_valid_q & w_inner))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_delay_q <= c_SEL_W'(1);
            out_hold_q  <= RESET_VAL;
        end else begin
            state_q     <= state_d;
            cur_delay_q <= cur_delay_d;
            out_hold_q  <= out_hold_d;
        end
    end

    assign out_valid = w_tap_valid;
    assign out_data  = w_tap_valid ? w_tap_data : out_hold_q;
    assign busy      = (state_q == RUN);
    assign cur_delay = cur_delay_q;

`ifdef VALUE_DELAY_LINE_OCC_EN
    logic [c_SEL_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + c_SEL_W'(in_valid) - c_SEL_W'(w_tap_valid);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`else
    // No occupancy counter in this build; busy is the only in-flight indication.
`endif

endmodule
`default_nettype wire

// File: tb/tb_value_delay_line.sv
`default_nettype none
// ==== tb_value_delay_line | directed vectors checked against a queue-of-ages latency model | rev 1.0 ====
module tb_value_delay_line;

    localparam int           W  = 4;
    localparam int           D  = 16;
    localparam int           SW = $clog2(D) + 1;
    localparam logic [W-1:0] RV = 4'hA;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic [SW-1:0] delay_sel = '0;
    logic          flush     = 1'b0;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          busy;
    logic [SW-1:0] cur_delay;

    int n_err    = 0;
    int n_checks = 0;

    // Model: each in-flight sample carries its age in edges; it is visible when age == latency.
    int           m_delay = 1;
    int           m_age[$];
    logic [W-1:0] m_dat[$];
    int           n_age[$];
    logic [W-1:0] n_dat[$];
    logic [W-1:0] m_last  = RV;
    logic         m_ov    = 1'b0;
    logic [SW-1:0] s_sel;

    value_delay_line #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .delay_sel (delay_sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .cur_delay (cur_delay)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int model_clamp(input logic [SW-1:0] s);
        if (s == '0) return 1;
        if (int'(s) > D) return D;
        return int'(s);
    endfunction

    function automatic void model_reset();
        m_age.delete();
        m_dat.delete();
        m_delay = 1;
        m_last  = RV;
        m_ov    = 1'b0;
    endfunction

    function automatic void model_update();
        bit idle_before;
        idle_before = (m_age.size() == 0);
        n_age.delete();
        n_dat.delete();
        if (!flush) begin
            foreach (m_age[i]) begin
                if (m_age[i] < m_delay) begin
                    n_age.push_back(m_age[i] + 1);
                    n_dat.push_back(m_dat[i]);
                end
            end
            if (in_valid) begin
                n_age.push_back(1);
                n_dat.push_back(in_data);
            end
        end
        m_age = n_age;
        m_dat = n_dat;
        if (idle_before && !in_valid) m_delay = model_clamp(delay_sel);
        m_ov = 1'b0;
        foreach (m_age[i]) begin
            if (m_age[i] == m_delay) begin
                m_ov   = 1'b1;
                m_last = m_dat[i];
            end
        end
    endfunction

    task automatic edge_only();
        @(posedge clk);
        model_update();
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic [SW-1:0] s, input logic f);
        in_valid  = v;
        in_data   = d;
        delay_sel = s;
        flush     = f;
        edge_only();
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("model out_valid", 32'(out_valid), 32'(m_ov));
            chk("model out_data", 32'(out_data), 32'(m_last));
            chk("model busy", 32'(busy), 32'(m_age.size() != 0));
            chk("model cur_delay", 32'(cur_delay), 32'(m_delay));
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'(0));
        chk("reset out_data", 32'(out_data), 32'(RV));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset cur_delay", 32'(cur_delay), 32'(1));
        reset = 1'b0;

        // Single sample, latency 10.
        step(1'b0, W'(0), SW'(10), 1'b0);
        chk("d10 cur_delay", 32'(cur_delay), 32'(10));
        chk("d10 pre out_data", 32'(out_data), 32'(RV));
        step(1'b1, W'(5), SW'(10), 1'b0);
        chk("d10 c1 out_valid", 32'(out_valid), 32'(0));
        for (int c = 2; c <= 10; c++) begin
            step(1'b0, W'(0), SW'(10), 1'b0);
            chk("d10 out_valid", 32'(out_valid), 32'(c == 10));
            if (c == 10) chk("d10 out_data", 32'(out_data), 32'(5));
        end
        step(1'b0, W'(0), SW'(3), 1'b0);
        chk("d10 after out_valid", 32'(out_valid), 32'(0));
        chk("d10 after hold", 32'(out_data), 32'(5));
        chk("d10 after busy", 32'(busy), 32'(0));
        step(1'b0, W'(0), SW'(3), 1'b0);

        // Back-to-back samples 1..4 at latency 3.
        for (int e = 0; e < 8; e++) begin
            step(e < 4, W'(e + 1), SW'(3), 1'b0);
            chk("d3 busy", 32'(busy), 32'((e + 1) <= 6));
            chk("d3 out_valid", 32'(out_valid), 32'((e + 1) >= 3 && (e + 1) <= 6));
            if ((e + 1) >= 3 && (e + 1) <= 6) chk("d3 out_data", 32'(out_data), 32'(e - 1));
        end

        // Latency change requested while busy only takes effect after draining.
        step(1'b1, W'(9), SW'(3), 1'b0);
        for (int c = 2; c <= 5; c++) begin
            step(1'b0, W'(0), SW'(7), 1'b0);
            chk("chg cur_delay", 32'(cur_delay), 32'((c <= 4) ? 3 : 7));
            if (c == 3) chk("chg d3 data", 32'(out_data), 32'(9));
        end
        step(1'b1, W'(4'hC), SW'(7), 1'b0);
        for (int c = 2; c <= 7; c++) begin
            step(1'b0, W'(0), SW'(7), 1'b0);
            chk("d7 out_valid", 32'(out_valid), 32'(c == 7));
            if (c == 7) chk("d7 out_data", 32'(out_data), 32'(4'hC));
        end

        // Clamping at both ends, then full-depth latency.
        step(1'b0, W'(0), SW'(0), 1'b0);
        step(1'b0, W'(0), SW'(0), 1'b0);
        chk("clamp low", 32'(cur_delay), 32'(1));
        step(1'b0, W'(0), SW'(D + 5), 1'b0);
        chk("clamp high", 32'(cur_delay), 32'(D));
        step(1'b1, W'(7), SW'(D + 5), 1'b0);
        for (int c = 2; c <= D; c++) begin
            step(1'b0, W'(0), SW'(D + 5), 1'b0);
            chk("d16 out_valid", 32'(out_valid), 32'(c == D));
        end
        chk("d16 out_data", 32'(out_data), 32'(7));

        // Latency 1, back to back.
        step(1'b0, W'(0), SW'(1), 1'b0);
        step(1'b0, W'(0), SW'(1), 1'b0);
        chk("d1 cur_delay", 32'(cur_delay), 32'(1));
        step(1'b1, W'(3), SW'(1), 1'b0);
        chk("d1 first", 32'(out_data), 32'(3));
        step(1'b1, W'(4), SW'(1), 1'b0);
        chk("d1 second", 32'(out_data), 32'(4));
        step(1'b0, W'(0), SW'(1), 1'b0);
        chk("d1 gap out_valid", 32'(out_valid), 32'(0));
        chk("d1 gap busy", 32'(busy), 32'(0));

        // Flush with three samples in flight and a fourth offered on the flush edge.
        step(1'b0, W'(0), SW'(5), 1'b0);
        step(1'b1, W'(1), SW'(5), 1'b0);
        step(1'b1, W'(2), SW'(5), 1'b0);
        step(1'b1, W'(3), SW'(5), 1'b0);
        chk("flush pre busy", 32'(busy), 32'(1));
        step(1'b1, W'(4'hF), SW'(5), 1'b1);
        chk("flush busy", 32'(busy), 32'(0));
        chk("flush out_valid", 32'(out_valid), 32'(0));
        chk("flush out_data", 32'(out_data), 32'(4));
        for (int c = 0; c < 6; c++) begin
            step(1'b0, W'(0), SW'(5), 1'b0);
            chk("flush drained", 32'(out_valid), 32'(0));
        end

        // Patterned stream with flushes and latency changes.
        for (int i = 0; i < 60; i++) begin
            s_sel = (i < 20) ? SW'(2) : ((i < 40) ? SW'(6) : SW'(13));
            step(i % 4 != 3, W'(i), s_sel, (i == 30) || (i == 50));
        end
        for (int i = 0; i < 20; i++) step(1'b0, W'(0), SW'(2), 1'b0);

        // Asynchronous reset in the middle of a stream.
        step(1'b1, W'(6), SW'(2), 1'b0);
        step(1'b1, W'(7), SW'(2), 1'b0);
        chk("mid out_data 6", 32'(out_data), 32'(6));
        step(1'b1, W'(8), SW'(2), 1'b0);
        chk("mid out_valid", 32'(out_valid), 32'(1));
        chk("mid out_data 7", 32'(out_data), 32'(7));
        in_valid = 1'b1;
        in_data  = W'(9);
        edge_only();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("areset out_valid", 32'(out_valid), 32'(0));
        chk("areset out_data", 32'(out_data), 32'(RV));
        chk("areset busy", 32'(busy), 32'(0));
        chk("areset cur_delay", 32'(cur_delay), 32'(1));
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, W'(0), SW'(3), 1'b0);
        chk("post reset cur_delay", 32'(cur_delay), 32'(3));
        chk("post reset out_data", 32'(out_data), 32'(RV));
        step(1'b1, W'(5), SW'(3), 1'b0);
        step(1'b0, W'(0), SW'(3), 1'b0);
        step(1'b0, W'(0), SW'(3), 1'b0);
        chk("post reset out_valid", 32'(out_valid), 32'(1));
        chk("post reset data", 32'(out_data), 32'(5));
        step(1'b0, W'(0), SW'(3), 1'b0);
        step(1'b0, W'(0), SW'(3), 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
